// File: rtl/pcstk_pkg.sv
// ---------------------------------------------------------------------------
// pcstk_pkg
//   Shared constants and enums for the PSQ PC-stack arbiter slice.
//   AW    : PC / stack entry width
//   DEPTH : number of stack entries
//   DW    : depth counter width (holds 0..DEPTH inclusive)
//   host_state_e : host access FSM states
//   grant_e      : which requester owns the stack port this cycle
// ---------------------------------------------------------------------------
package pcstk_pkg;
  localparam int AW    = 14;
  localparam int DEPTH = 16;
  localparam int DW    = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {H_IDLE, H_WAIT, H_ACK} host_state_e;
  typedef enum logic [1:0] {G_NONE, G_IRQ, G_SEQ, G_HOST} grant_e;
endpackage

// File: rtl/pcstk_arb_ctl_if.sv
// ---------------------------------------------------------------------------
// pcstk_arb_ctl_if
//   Host/debug register-port handshake into the PC-stack arbiter.
//   host_req   : request, held by the host until host_ack
//   host_wr    : 1 = push host_wdata, 0 = pop into host_rdata
//   host_wdata : push data
//   host_ack   : 1-cycle completion pulse
//   host_rdata : popped value, valid from host_ack until the next host pop
//   modport master : host side;  modport slave : arbiter side
// ---------------------------------------------------------------------------
interface pcstk_arb_ctl_if;
  import pcstk_pkg::*;

  logic          host_req;
  logic          host_wr;
  logic [AW-1:0] host_wdata;
  logic          host_ack;
  logic [AW-1:0] host_rdata;

  modport master (output host_req, host_wr, host_wdata,
                  input  host_ack, host_rdata);
  modport slave  (input  host_req, host_wr, host_wdata,
                  output host_ack, host_rdata);
endinterface

// File: rtl/pcstk_host_if.sv
// ---------------------------------------------------------------------------
// pcstk_host_if
//   Host access sequencer: latches a host request, waits for the arbiter to
//   grant it, captures TopPC on a granted pop and pulses host_ack.
//   PCSCLK     in  clock
//   T_RST      in  asynchronous active-high reset
//   host_req   in  host request level
//   host_wr    in  1 = push, 0 = pop
//   TopPC      in  current top of stack (captured on the pop edge)
//   host_gnt   in  arbiter grants the stack to the host this cycle
//   host_pend  out host access waiting for a grant
//   host_ack   out 1-cycle completion pulse
//   host_rdata out popped value
// ---------------------------------------------------------------------------
module pcstk_host_if
  import pcstk_pkg::*;
(
  input  logic          PCSCLK,
  input  logic          T_RST,
  input  logic          host_req,
  input  logic          host_wr,
  input  logic [AW-1:0] TopPC,
  input  logic          host_gnt,
  output logic          host_pend,
  output logic          host_ack,
  output logic [AW-1:0] host_rdata
);

  host_state_e   state_q, state_d;
  logic [AW-1:0] rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    unique case (state_q)
      H_IDLE: if (host_req) state_d = H_WAIT;
      H_WAIT: begin
        if (host_gnt) begin
          state_d = H_ACK;
          // The stack pops on this same edge, so TopPC is still the old top.
          if (!host_wr) rdata_d = TopPC;
        end
      end
      H_ACK:  state_d = H_IDLE;
      default: state_d = H_IDLE;
    endcase
  end

  always_ff @(posedge PCSCLK or posedge T_RST) begin
    if (T_RST) begin
      state_q <= H_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  assign host_pend  = (state_q == H_WAIT);
  assign host_ack   = (state_q == H_ACK);
  assign host_rdata = rdata_q;

endmodule

// File: rtl/pcstk_arb_ctl.sv
// ---------------------------------------------------------------------------
// pcstk_arb_ctl
//   Arbitrates the 16x14 PSQ PC stack between interrupt entry/RTI, the
//   program sequencer and the host port. One stack operation per cycle,
//   fixed priority irq > seq > host, grant path combinational.
//   Tracks depth and raises sticky overflow/underflow flags.
//
//   Optional build macro PCSTK_OVF_IRQ_EN adds output ovf_irq: a 1-cycle
//   pulse on each rising edge of (stk_ovf | stk_unf).
//
//   Ports:
//   PCSCLK, T_RST          clock, asynchronous active-high reset
//   irq_push/irq_pop/irq_pc interrupt entry push / RTI pop
//   seq_push/seq_pop/seq_pc sequencer requests (level), seq_stall out
//   hbus (slave)           host request/ack handshake
//   err_clr                clears stk_ovf/stk_unf (a same-cycle set wins)
//   PC_full/PC_empty/TopPC stack status
//   PushPC_EN/PopPC_EN/PCin stack strobes and push data
//   PCS_CKenb              1 = stack clock disabled (no op this cycle)
//   stk_depth/stk_ovf/stk_unf depth and sticky error flags
// ---------------------------------------------------------------------------
module pcstk_arb_ctl
  import pcstk_pkg::*;
(
  input  logic          PCSCLK,
  input  logic          T_RST,
  input  logic          irq_push,
  input  logic          irq_pop,
  input  logic [AW-1:0] irq_pc,
  input  logic          seq_push,
  input  logic          seq_pop,
  input  logic [AW-1:0] seq_pc,
  output logic          seq_stall,
  pcstk_arb_ctl_if.slave hbus,
  input  logic          err_clr,
  input  logic          PC_full,
  input  logic          PC_empty,
  input  logic [AW-1:0] TopPC,
  output logic          PushPC_EN,
  output logic          PopPC_EN,
  output logic [AW-1:0] PCin,
  output logic          PCS_CKenb,
  output logic [DW-1:0] stk_depth,
  output logic          stk_ovf,
  output logic          stk_unf
`ifdef PCSTK_OVF_IRQ_EN
  ,
  output logic          ovf_irq
`endif
);

  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  grant_e        gnt;
  logic          irq_any, seq_any, seq_one;
  logic          push_en, pop_en, host_gnt, host_pend, irq_both;
  logic [AW-1:0] pc_mux;
  logic          host_ack_w;
  logic [AW-1:0] host_rdata_w;

  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;

  assign irq_any = irq_push | irq_pop;
  assign seq_any = seq_push | seq_pop;
  assign seq_one = seq_push ^ seq_pop;

  // Winner selection. A simultaneous seq push+pop still occupies the
  // sequencer slot but is a no-op: nothing is granted that cycle, so the
  // host does not slip in underneath it.
  always_comb begin
    gnt = G_NONE;
    if (!T_RST) begin
      if (irq_any)        gnt = G_IRQ;
      else if (seq_any)   gnt = seq_one ? G_SEQ : G_NONE;
      else if (host_pend) gnt = G_HOST;
    end
  end

  always_comb begin
    push_en  = 1'b0;
    pop_en   = 1'b0;
    pc_mux   = '0;
    host_gnt = 1'b0;
    unique case (gnt)
      G_IRQ: begin
        // Push wins over a same-cycle RTI; the lost pop is flagged below.
        push_en = irq_push;
        pop_en  = irq_pop & ~irq_push;
        if (irq_push) pc_mux = irq_pc;
      end
      G_SEQ: begin
        push_en = seq_push;
        pop_en  = seq_pop;
        if (seq_push) pc_mux = seq_pc;
      end
      G_HOST: begin
        host_gnt = 1'b1;
        push_en  = hbus.host_wr;
        pop_en   = ~hbus.host_wr;
        if (hbus.host_wr) pc_mux = hbus.host_wdata;
      end
      default: ;
    endcase
  end

  assign irq_both  = ~T_RST & irq_push & irq_pop;
  assign seq_stall = ~T_RST & seq_one & irq_any;

  assign PushPC_EN = push_en;
  assign PopPC_EN  = pop_en;
  assign PCin      = pc_mux;
  assign PCS_CKenb = ~(push_en | pop_en);

  // Depth tracks only operations the stack actually performs; a strobe
  // into a full/empty stack is ignored there and flagged here instead.
  always_comb begin
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (push_en && !PC_full && depth_q != DEPTH_MAX) depth_d = depth_q + DW'(1);
    else if (pop_en && !PC_empty && depth_q != '0)   depth_d = depth_q - DW'(1);

    if (push_en && PC_full)                  ovf_d = 1'b1;
    else if (err_clr)                        ovf_d = 1'b0;

    if ((pop_en && PC_empty) || irq_both)    unf_d = 1'b1;
    else if (err_clr)                        unf_d = 1'b0;
  end

  always_ff @(posedge PCSCLK or posedge T_RST) begin
    if (T_RST) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign stk_depth = depth_q;
  assign stk_ovf   = ovf_q;
  assign stk_unf   = unf_q;

`ifdef PCSTK_OVF_IRQ_EN
  logic ovf_irq_q, ovf_irq_d;

  // Fires in the same cycle the combined error flag first becomes visible.
  always_comb begin
    ovf_irq_d = (ovf_d | unf_d) & ~(ovf_q | unf_q);
  end

  always_ff @(posedge PCSCLK or posedge T_RST) begin
    if (T_RST) ovf_irq_q <= 1'b0;
    else       ovf_irq_q <= ovf_irq_d;
  end

  assign ovf_irq = ovf_irq_q;
`endif

  pcstk_host_if u_host (
    .PCSCLK     (PCSCLK),
    .T_RST      (T_RST),
    .host_req   (hbus.host_req),
    .host_wr    (hbus.host_wr),
    .TopPC      (TopPC),
    .host_gnt   (host_gnt),
    .host_pend  (host_pend),
    .host_ack   (host_ack_w),
    .host_rdata (host_rdata_w)
  );

  assign hbus.host_ack   = host_ack_w;
  assign hbus.host_rdata = host_rdata_w;

endmodule

// File: tb/tb_pcstk_arb_ctl.sv
// ---------------------------------------------------------------------------
// tb_pcstk_arb_ctl
//   Directed scenarios followed by randomized traffic. The bench plays the
//   role of the PC stack itself (a queue) and predicts every strobe, depth,
//   flag and host handshake from the arbitration rules.
// ---------------------------------------------------------------------------
module tb_pcstk_arb_ctl;
  import pcstk_pkg::*;

  logic          PCSCLK = 1'b0;
  logic          T_RST;
  logic          irq_push, irq_pop, seq_push, seq_pop, err_clr;
  logic [AW-1:0] irq_pc, seq_pc, TopPC, PCin;
  logic          PC_full, PC_empty;
  logic          seq_stall, PushPC_EN, PopPC_EN, PCS_CKenb, stk_ovf, stk_unf;
  logic [DW-1:0] stk_depth;
`ifdef PCSTK_OVF_IRQ_EN
  logic          ovf_irq;
`endif

  pcstk_arb_ctl_if hbus();

  pcstk_arb_ctl dut (
    .PCSCLK    (PCSCLK),
    .T_RST     (T_RST),
    .irq_push  (irq_push),
    .irq_pop   (irq_pop),
    .irq_pc    (irq_pc),
    .seq_push  (seq_push),
    .seq_pop   (seq_pop),
    .seq_pc    (seq_pc),
    .seq_stall (seq_stall),
    .hbus      (hbus),
    .err_clr   (err_clr),
    .PC_full   (PC_full),
    .PC_empty  (PC_empty),
    .TopPC     (TopPC),
    .PushPC_EN (PushPC_EN),
    .PopPC_EN  (PopPC_EN),
    .PCin      (PCin),
    .PCS_CKenb (PCS_CKenb),
    .stk_depth (stk_depth),
    .stk_ovf   (stk_ovf),
    .stk_unf   (stk_unf)
`ifdef PCSTK_OVF_IRQ_EN
    ,
    .ovf_irq   (ovf_irq)
`endif
  );

  always #5 PCSCLK = ~PCSCLK;

  int checks = 0;
  int errors = 0;

  // reference model state
  int stk[$];
  int m_depth;
  bit m_ovf, m_unf, m_irq;
  bit h_wait, h_ack;
  int m_rdata;
  bit last_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    irq_push = 0; irq_pop = 0; irq_pc = '0;
    seq_push = 0; seq_pop = 0; seq_pc = '0;
    err_clr  = 0;
    hbus.host_req = 0; hbus.host_wr = 0; hbus.host_wdata = '0;
  endtask

  task automatic model_clear();
    stk.delete();
    m_depth = 0; m_ovf = 0; m_unf = 0; m_irq = 0;
    h_wait = 0; h_ack = 0; m_rdata = 0; last_stall = 0;
  endtask

  task automatic set_stack_status();
    PC_full  = (stk.size() >= DEPTH);
    PC_empty = (stk.size() == 0);
    TopPC    = (stk.size() == 0) ? '0 : AW'(stk[$]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_push"},  PushPC_EN, 0);
    chk({tag, "_pop"},   PopPC_EN, 0);
    chk({tag, "_pcin"},  PCin, 0);
    chk({tag, "_ckenb"}, PCS_CKenb, 1);
    chk({tag, "_stall"}, seq_stall, 0);
    chk({tag, "_ack"},   hbus.host_ack, 0);
    chk({tag, "_rdata"}, hbus.host_rdata, 0);
    chk({tag, "_depth"}, stk_depth, 0);
    chk({tag, "_ovf"},   stk_ovf, 0);
    chk({tag, "_unf"},   stk_unf, 0);
`ifdef PCSTK_OVF_IRQ_EN
    chk({tag, "_ovfirq"}, ovf_irq, 0);
`endif
  endtask

  // One clock cycle with the currently driven requests: check the
  // combinational grant, advance the model, then check registered state.
  task automatic step();
    bit irq_any, seq_any, seq_one, host_go, e_push, e_pop, full, empty;
    bit old_ack, err_before;
    int e_pc, top_now;
    set_stack_status();
    full = PC_full; empty = PC_empty; top_now = int'(TopPC);
    #2;
    irq_any = irq_push || irq_pop;
    seq_any = seq_push || seq_pop;
    seq_one = seq_push != seq_pop;
    host_go = h_wait && !irq_any && !seq_any;
    e_push = 0; e_pop = 0; e_pc = 0;
    if (irq_any) begin
      e_push = irq_push; e_pop = irq_pop && !irq_push;
      if (irq_push) e_pc = int'(irq_pc);
    end else if (seq_one) begin
      e_push = seq_push; e_pop = seq_pop;
      if (seq_push) e_pc = int'(seq_pc);
    end else if (host_go) begin
      e_push = hbus.host_wr; e_pop = !hbus.host_wr;
      if (hbus.host_wr) e_pc = int'(hbus.host_wdata);
    end
    chk("push_en", PushPC_EN, e_push);
    chk("pop_en", PopPC_EN, e_pop);
    chk("pcin", PCin, e_pc);
    chk("ckenb", PCS_CKenb, !(e_push || e_pop));
    chk("seq_stall", seq_stall, seq_one && irq_any);
    chk("host_ack_c", hbus.host_ack, h_ack);
    last_stall = seq_one && irq_any;

    err_before = m_ovf || m_unf;
    if (e_push && full) m_ovf = 1; else if (err_clr) m_ovf = 0;
    if ((e_pop && empty) || (irq_push && irq_pop)) m_unf = 1; else if (err_clr) m_unf = 0;
    m_irq = (m_ovf || m_unf) && !err_before;
    if (e_push && !full) begin stk.push_back(e_pc); if (m_depth < DEPTH) m_depth++; end
    if (e_pop && !empty) begin void'(stk.pop_back()); if (m_depth > 0) m_depth--; end
    old_ack = h_ack;
    h_ack = host_go;
    if (host_go) begin
      h_wait = 0;
      if (!hbus.host_wr) m_rdata = top_now;
    end else if (!h_wait && !old_ack && hbus.host_req) begin
      h_wait = 1;
    end

    @(posedge PCSCLK); #1;
    chk("depth", stk_depth, m_depth);
    chk("ovf", stk_ovf, m_ovf);
    chk("unf", stk_unf, m_unf);
    chk("host_ack", hbus.host_ack, h_ack);
    chk("host_rdata", hbus.host_rdata, m_rdata);
`ifdef PCSTK_OVF_IRQ_EN
    chk("ovf_irq", ovf_irq, m_irq);
`endif
    if (h_ack) hbus.host_req = 0;
  endtask

  initial begin
    int ppush, ppop;
    T_RST = 1;
    drive_idle();
    model_clear();
    set_stack_status();
    repeat (2) @(posedge PCSCLK);
    #1;
    chk_reset_outputs("reset");
    T_RST = 0;

    // fill the stack from the sequencer
    for (int i = 0; i < 16; i++) begin
      seq_push = 1; seq_pc = AW'(14'h100 + i);
      step();
    end
    seq_push = 0;
    chk("fill_depth", stk_depth, 16);
    chk("fill_ovf", stk_ovf, 0);

    // push into a full stack, then clear the flag
    seq_push = 1; seq_pc = 14'h110;
    step();
    seq_push = 0;
    chk("full_ovf", stk_ovf, 1);
    chk("full_depth", stk_depth, 16);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("clr_ovf", stk_ovf, 0);

    // irq preempts a held sequencer push
    seq_pop = 1; step(); step(); seq_pop = 0;
    seq_push = 1; seq_pc = 14'h155; irq_push = 1; irq_pc = 14'h2AB;
    set_stack_status(); #1;
    chk("pre_pcin", PCin, 14'h2AB);
    chk("pre_stall", seq_stall, 1);
    step();
    irq_push = 0;
    set_stack_status(); #1;
    chk("seq_after_pcin", PCin, 14'h155);
    chk("seq_after_stall", seq_stall, 0);
    step();
    seq_push = 0;

    // host pop of a known top value
    seq_pop = 1; step(); seq_pop = 0;
    seq_push = 1; seq_pc = 14'h1234; step(); seq_push = 0;
    hbus.host_req = 1; hbus.host_wr = 0;
    step();
    chk("host_ack_early", hbus.host_ack, 0);
    step();
    chk("host_ack_lat", hbus.host_ack, 1);
    chk("host_rdata_1234", hbus.host_rdata, 14'h1234);
    chk("host_pop_depth", stk_depth, 15);
    step();

    // host push
    hbus.host_req = 1; hbus.host_wr = 1; hbus.host_wdata = 14'h3A5;
    step(); step();
    chk("host_push_ack", hbus.host_ack, 1);
    chk("host_push_depth", stk_depth, 16);
    step();

    // drain, then RTI on an empty stack
    for (int i = 0; i < 16; i++) begin
      seq_pop = 1; step();
    end
    seq_pop = 0;
    irq_pop = 1;
    step();
    irq_pop = 0;
    chk("empty_unf", stk_unf, 1);
    chk("empty_depth", stk_depth, 0);
    step();

    // reset while the host waits behind the sequencer
    hbus.host_req = 1; hbus.host_wr = 0;
    seq_push = 1; seq_pc = 14'h0AA;
    step(); step();
    T_RST = 1;
    #1;
    chk("rstw_push", PushPC_EN, 0);
    chk("rstw_ckenb", PCS_CKenb, 1);
    chk("rstw_stall", seq_stall, 0);
    chk("rstw_depth", stk_depth, 0);
    chk("rstw_unf", stk_unf, 0);
    seq_push = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge PCSCLK); #1;
      chk("rstw_ack", hbus.host_ack, 0);
      chk("rstw_ckenb2", PCS_CKenb, 1);
    end
    chk_reset_outputs("rstw");
    hbus.host_req = 0;
    T_RST = 0;
    model_clear();

    // randomized traffic with alternating push/pop bias
    ppush = 50; ppop = 30;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        case ((c / 200) % 3)
          0: begin ppush = 60; ppop = 20; end
          1: begin ppush = 20; ppop = 60; end
          default: begin ppush = 40; ppop = 40; end
        endcase
      end
      begin
        int r;
        r = int'($urandom_range(0, 15));
        irq_push = (r == 0) || (r == 2);
        irq_pop  = (r == 1) || (r == 2);
        irq_pc   = AW'($urandom);
      end
      if (!last_stall) begin
        seq_push = ($urandom_range(0, 99) < ppush);
        seq_pop  = ($urandom_range(0, 99) < ppop);
        seq_pc   = AW'($urandom);
      end
      err_clr = ($urandom_range(0, 15) == 0);
      if (!hbus.host_req && $urandom_range(0, 7) == 0) begin
        hbus.host_req   = 1;
        hbus.host_wr    = $urandom_range(0, 1) == 1;
        hbus.host_wdata = AW'($urandom);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
